pipelined_chunk_adder: RTL
==========================

Name: pipelined_chunk_adder

Overview:
Parametrised pipelined adder. Adds two WIDTH-bit operands CHUNK bits per pipeline stage, with a registered carry chain between stages.
Generalises the fixed 4-bit two-chunk adder to arbitrary width and chunk count, adding a valid/ready handshake and full back-pressure.
Sits in the arithmetic datapath as a drop-in wide adder where a single-cycle ripple carry cannot meet timing.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per pipeline stage; 1 <= CHUNK <= WIDTH.
STAGES, WIDTH/CHUNK, derived local constant: pipeline depth. Not overridable.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operand pair a/b is valid.
in_ready  output  1  block accepts operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
out_valid  output  1  sum is valid.
out_ready  input  1  downstream accepts sum.
sum  output  WIDTH+1  result; sum[WIDTH] is the carry-out.

Behaviour:
- Pipeline registers:
  - Stage k (0..STAGES-1) holds valid_k, carry_k, and result chunks 0..k.
  - It also holds the unconsumed operand chunks k+1..STAGES-1 of a and b (skewed datapath).
- Stage k computes {c, r} = a_chunk_k + b_chunk_k + carry_in:
  - carry_in is 0 for stage 0 (1 with subtract, see Optional Feature); otherwise carry_{k-1}.
  - The sum is CHUNK+1 bits wide, with no truncation until the final result.
- Handshake:
  - ready_k = !valid_k || ready_{k+1}; ready_STAGES = out_ready.
  - in_ready = ready_0. It is combinational through out_ready and is documented as such.
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - Operands are sampled only on transfer in; a/b are don't-care otherwise.
- Throughput and latency:
  - Throughput is one operation per cycle when out_ready is held high.
  - Latency is STAGES cycles: out_valid is asserted STAGES edges after the accepting edge.
- Output:
  - out_valid = valid_{STAGES-1}.
  - sum = {carry_{STAGES-1}, result chunks}. It is stable while out_valid && !out_ready.
- Ordering is strictly FIFO; no operation is dropped or duplicated.
- Bubbles collapse: an empty stage accepts from upstream even when downstream is stalled.
- Full pipeline with out_ready low: in_ready is low, and all STAGES entries are held.
- Simultaneous in and out transfer when full: legal; the pipeline shifts by one.
- Reset (rst_n low at an edge):
  - Clears all valid_k, carry_k and data registers to 0, so out_valid = 0 and sum = 0 from the next cycle.
  - in_ready reads 1 after reset.
  - Reset mid-operation discards in-flight results; no partial result is emitted.
- CHUNK == WIDTH: a single stage; latency is 1.
- Wrap-around: the carry-out is exact. 2^WIDTH-1 + 2^WIDTH-1 = 2^(WIDTH+1)-2, with no overflow in sum.

Optional Feature:
Macro: PIPELINED_CHUNK_ADDER_SUB_EN.
- Defined:
  - Adds an input port op_sub (1 bit), sampled with the operands and carried down the pipeline.
  - When op_sub = 1 the block computes a + ~b + 1: b is inverted per chunk and the stage-0 carry-in is 1.
  - sum[WIDTH] = 1 means no borrow (a >= b, unsigned).
- Undefined: no op_sub port; the block is add-only and the stage-0 carry-in is tied to 0.

Decomposition:
- Package pipelined_chunk_adder_pkg holds:
  - default WIDTH/CHUNK constants;
  - the stage record typedef (valid, carry, op_sub when enabled, result, remaining a/b);
  - a function for the chunk index slice base.
- One sub-module, chunk_add_stage, is natural:
  - a single registered stage of CHUNK+1-bit add plus ready logic;
  - instantiated STAGES times in a generate loop.

Test Plan:
- Basic: WIDTH=16, CHUNK=4, out_ready=1; a=0xFFFF, b=0x0001 -> after 4 cycles out_valid=1, sum=0x10000. Also a=0x1234, b=0x4321 -> sum=0x05555.
- Streaming: 100 random back-to-back pairs with out_ready=1 -> in_ready stays 1, one result per cycle, order and values match the reference model, latency 4.
- Back-pressure: hold out_ready=0 and push 6 pairs -> exactly 4 accepted, then in_ready=0 and sum held stable. Release out_ready -> remaining 2 accepted, 6 correct results in order.
- Reset mid-flight: accept 3 pairs, assert rst_n=0 for 1 cycle -> out_valid=0, sum=0, in_ready=1 next cycle, and no stale result ever appears.
- Edge widths: WIDTH=8, CHUNK=8 -> latency 1, 0xFF+0xFF=0x1FE. WIDTH=8, CHUNK=1 -> latency 8, 0x80+0x80=0x100.
- Subtract (PIPELINED_CHUNK_ADDER_SUB_EN defined): a=0x0003, b=0x0005, op_sub=1 -> sum=0x0FFFE (borrow). a=0x0005, b=0x0003 -> sum=0x10002. Interleaved add/sub ops each keep their own op_sub.

Source files
------------

// File: rtl/pipelined_chunk_adder_pkg.sv
// Shared constants, stage control record and slice helper for pipelined_chunk_adder.
// Subtract support is enabled by defining PIPELINED_CHUNK_ADDER_SUB_EN.
package pipelined_chunk_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    // Per-stage control bits; the result and operand vectors are sized by the user of the record.
    typedef struct packed {
        logic valid;
        logic carry;
        logic op_sub;
    } stage_ctl_t;

    function automatic int chunk_base(input int idx, input int chunk);
        return idx * chunk;
    endfunction

endpackage

// File: rtl/pipelined_chunk_adder_stage.sv
// One registered pipeline stage: adds chunk IDX of the operands plus the incoming carry
// and forwards the partial result and operands to the next stage.
module chunk_add_stage
    import pipelined_chunk_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic             up_carry,
    input  logic             up_op_sub,
    input  logic [WIDTH-1:0] up_res,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic             carry,
    output logic             op_sub,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] a_rem,
    output logic [WIDTH-1:0] b_rem
);

    localparam int BASE = chunk_base(IDX, CHUNK);

    stage_ctl_t       ctl_q;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        b_chunk   = up_op_sub ? ~up_b[BASE +: CHUNK] : up_b[BASE +: CHUNK];
        chunk_sum = {1'b0, up_a[BASE +: CHUNK]} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, up_carry};
        res_next  = up_res;
        res_next[BASE +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    assign ready = !ctl_q.valid || down_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl_q <= '0;
            res   <= '0;
            a_rem <= '0;
            b_rem <= '0;
        end else if (ready) begin
            ctl_q.valid <= up_valid;
            // Data only moves with a real operation so a bubble never disturbs held state.
            if (up_valid) begin
                ctl_q.carry  <= chunk_sum[CHUNK];
                ctl_q.op_sub <= up_op_sub;
                res          <= res_next;
                a_rem        <= up_a;
                b_rem        <= up_b;
            end
        end
    end

    assign valid  = ctl_q.valid;
    assign carry  = ctl_q.carry;
    assign op_sub = ctl_q.op_sub;

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined WIDTH-bit adder, CHUNK bits per stage with a registered carry chain.
// Define PIPELINED_CHUNK_ADDER_SUB_EN to add the op_sub port (a - b as a + ~b + 1).
module pipelined_chunk_adder
    import pipelined_chunk_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int STAGES = WIDTH / CHUNK;

    // Handshake: a transfer happens on an edge where valid && ready. Stage k is ready when it is
    // empty or stage k+1 is ready, so in_ready is combinational from out_ready through every stage.
    logic first_op_sub;
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
    assign first_op_sub = op_sub;
`else
    assign first_op_sub = 1'b0;
`endif

    logic [STAGES-1:0] st_valid, st_carry, st_op_sub, stage_ready, down_ready;
    logic [STAGES-1:0] up_valid, up_carry, up_op_sub;
    logic [WIDTH-1:0]  st_res [STAGES];
    logic [WIDTH-1:0]  st_a   [STAGES];
    logic [WIDTH-1:0]  st_b   [STAGES];
    logic [WIDTH-1:0]  up_res [STAGES];
    logic [WIDTH-1:0]  up_a   [STAGES];
    logic [WIDTH-1:0]  up_b   [STAGES];

    // Unrolled ready chain: stage k may advance when out_ready is high or any later stage is empty.
    always_comb begin
        down_ready = '0;
        for (int k = 0; k < STAGES; k++) begin
            down_ready[k] = out_ready;
            for (int j = k + 1; j < STAGES; j++) begin
                if (!st_valid[j]) down_ready[k] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign up_valid[0]  = in_valid;
            assign up_carry[0]  = first_op_sub;
            assign up_op_sub[0] = first_op_sub;
            assign up_res[0]    = '0;
            assign up_a[0]      = a;
            assign up_b[0]      = b;
        end else begin : g_link
            assign up_valid[k]  = st_valid[k-1];
            assign up_carry[k]  = st_carry[k-1];
            assign up_op_sub[k] = st_op_sub[k-1];
            assign up_res[k]    = st_res[k-1];
            assign up_a[k]      = st_a[k-1];
            assign up_b[k]      = st_b[k-1];
        end

        chunk_add_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid   (up_valid[k]),
            .up_carry   (up_carry[k]),
            .up_op_sub  (up_op_sub[k]),
            .up_res     (up_res[k]),
            .up_a       (up_a[k]),
            .up_b       (up_b[k]),
            .down_ready (down_ready[k]),
            .ready      (stage_ready[k]),
            .valid      (st_valid[k]),
            .carry      (st_carry[k]),
            .op_sub     (st_op_sub[k]),
            .res        (st_res[k]),
            .a_rem      (st_a[k]),
            .b_rem      (st_b[k])
        );
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = st_valid[STAGES-1];
    assign sum       = {st_carry[STAGES-1], st_res[STAGES-1]};

    // Operands and op_sub are fully consumed by the last stage.
    logic unused_tail;
    assign unused_tail = ^{st_op_sub[STAGES-1], st_a[STAGES-1], st_b[STAGES-1], stage_ready};

endmodule
